// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I datapath: fetch, register read,
// execute, load/store and halt, with a retired-instruction counter.
module rv32i_ctrl_fsm #(
  parameter int HALT_ON_SYSTEM = 1,
  parameter int ILLEGAL_TRAP   = 1,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      instr,
  input  logic             branch_taken,
  input  logic             mem_ready,
  input  logic [1:0]       addr_lsb,
  output logic             mem_rstrb,
  output logic [3:0]       mem_wmask,
  output logic             addr_sel,
  output logic             instr_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state_o,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] S_FETCH_INSTR = 3'd0;
  localparam logic [2:0] S_WAIT_INSTR  = 3'd1;
  localparam logic [2:0] S_FETCH_REGS  = 3'd2;
  localparam logic [2:0] S_EXECUTE     = 3'd3;
  localparam logic [2:0] S_LOAD        = 3'd4;
  localparam logic [2:0] S_WAIT_DATA   = 3'd5;
  localparam logic [2:0] S_STORE       = 3'd6;
  localparam logic [2:0] S_HALT        = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [2:0]       r_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;

  logic [2:0] w_next_state;
  logic       w_rf_we_raw;
  logic       w_retire;
  logic       w_trap;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_rd_zero;
  logic       w_is_load;
  logic       w_is_store;
  logic       w_is_system;
  logic       w_known_op;
  logic       w_half;
  logic       w_word;
  logic       w_misaligned;
  logic       w_store_bad;
  logic       w_bad_instr;
  logic       w_unused;

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] lsb);
    case (f3)
      3'b000:  store_mask = 4'b0001 << lsb;
      3'b001:  store_mask = 4'b0011 << {lsb[1], 1'b0};
      3'b010:  store_mask = 4'b1111;
      default: store_mask = 4'b0000;
    endcase
  endfunction

  assign w_opcode    = instr[6:0];
  assign w_funct3    = instr[14:12];
  assign w_rd_zero   = (instr[11:7] == 5'd0);
  assign w_unused    = ^instr[31:15];

  assign w_is_load   = (w_opcode == OP_LOAD);
  assign w_is_store  = (w_opcode == OP_STORE);
  assign w_is_system = (w_opcode == OP_SYSTEM);

  always_comb begin
    w_known_op = 1'b0;
    case (w_opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
      OP_ALUIMM, OP_ALUREG, OP_FENCE, OP_SYSTEM: w_known_op = 1'b1;
      default:                                   w_known_op = 1'b0;
    endcase
  end

  // funct3[1:0] selects access size for both loads and stores; byte never faults
  assign w_half       = (w_funct3[1:0] == 2'b01);
  assign w_word       = (w_funct3[1:0] == 2'b10);
  assign w_misaligned = (w_is_load | w_is_store) &
                        ((w_half & addr_lsb[0]) | (w_word & (addr_lsb != 2'b00)));
  assign w_store_bad  = w_is_store & (w_funct3 > 3'b010);
  assign w_bad_instr  = ~w_known_op | w_misaligned | w_store_bad;

  always_comb begin
    mem_rstrb    = 1'b0;
    mem_wmask    = 4'b0000;
    addr_sel     = 1'b0;
    instr_we     = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'd0;
    wb_sel       = 2'd0;
    w_rf_we_raw  = 1'b0;
    w_retire     = 1'b0;
    w_trap       = 1'b0;
    w_next_state = r_state;
    case (r_state)
      S_FETCH_INSTR: begin
        mem_rstrb    = 1'b1;
        w_next_state = S_WAIT_INSTR;
      end
      S_WAIT_INSTR: begin
        if (mem_ready) begin
          instr_we     = 1'b1;
          w_next_state = S_FETCH_REGS;
        end
      end
      S_FETCH_REGS: begin
        w_next_state = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (w_bad_instr) begin
          if (ILLEGAL_TRAP != 0) begin
            w_trap       = 1'b1;
            w_next_state = S_HALT;
          end else begin
            pc_we        = 1'b1;
            w_retire     = 1'b1;
            w_next_state = S_FETCH_INSTR;
          end
        end else if (w_is_system && (HALT_ON_SYSTEM != 0)) begin
          w_next_state = S_HALT;
        end else if (w_is_load) begin
          w_next_state = S_LOAD;
        end else if (w_is_store) begin
          w_next_state = S_STORE;
        end else begin
          pc_we        = 1'b1;
          w_retire     = 1'b1;
          w_next_state = S_FETCH_INSTR;
          case (w_opcode)
            OP_ALUREG, OP_ALUIMM: begin
              w_rf_we_raw = 1'b1;
              wb_sel      = 2'd0;
            end
            OP_LUI, OP_AUIPC: begin
              w_rf_we_raw = 1'b1;
              wb_sel      = 2'd3;
            end
            OP_JAL: begin
              w_rf_we_raw = 1'b1;
              wb_sel      = 2'd1;
              pc_sel      = 2'd1;
            end
            OP_JALR: begin
              w_rf_we_raw = 1'b1;
              wb_sel      = 2'd1;
              pc_sel      = 2'd2;
            end
            OP_BRANCH: begin
              pc_sel = branch_taken ? 2'd1 : 2'd0;
            end
            default: begin
              pc_sel = 2'd0;
            end
          endcase
        end
      end
      S_LOAD: begin
        mem_rstrb    = 1'b1;
        addr_sel     = 1'b1;
        w_next_state = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        addr_sel = 1'b1;
        if (mem_ready) begin
          w_rf_we_raw  = 1'b1;
          wb_sel       = 2'd2;
          pc_we        = 1'b1;
          w_retire     = 1'b1;
          w_next_state = S_FETCH_INSTR;
        end
      end
      S_STORE: begin
        // address and mask stay asserted for the whole handshake
        addr_sel  = 1'b1;
        mem_wmask = store_mask(w_funct3, addr_lsb);
        if (mem_ready) begin
          pc_we        = 1'b1;
          w_retire     = 1'b1;
          w_next_state = S_FETCH_INSTR;
        end
      end
      default: begin
        w_next_state = S_HALT;
      end
    endcase
  end

  assign rf_we = w_rf_we_raw & ~w_rd_zero;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_FETCH_INSTR;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_trap) begin
        r_illegal <= 1'b1;
      end
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  assign state_o = r_state;
  assign halted  = (r_state == S_HALT);
  assign illegal = r_illegal;
  assign instret = r_instret;

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Bench for rv32i_ctrl_fsm: a trapping/halting instance and a NOP-on-fault
// instance with a 2-bit counter, driven in lockstep; retirements are scoreboarded.
module tb_rv32i_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [31:0] instr;
  logic        branch_taken;
  logic        mem_ready;
  logic [1:0]  addr_lsb;

  logic        a_mem_rstrb, a_addr_sel, a_instr_we, a_pc_we, a_rf_we, a_halted, a_illegal;
  logic [3:0]  a_mem_wmask;
  logic [1:0]  a_pc_sel, a_wb_sel;
  logic [2:0]  a_state;
  logic [31:0] a_instret;

  logic        b_mem_rstrb, b_addr_sel, b_instr_we, b_pc_we, b_rf_we, b_halted, b_illegal;
  logic [3:0]  b_mem_wmask;
  logic [1:0]  b_pc_sel, b_wb_sel;
  logic [2:0]  b_state;
  logic [1:0]  b_instret;

  rv32i_ctrl_fsm #(.HALT_ON_SYSTEM(1), .ILLEGAL_TRAP(1), .CNT_W(32)) u_dut (
    .clk(clk), .resetn(resetn), .instr(instr), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .addr_lsb(addr_lsb), .mem_rstrb(a_mem_rstrb),
    .mem_wmask(a_mem_wmask), .addr_sel(a_addr_sel), .instr_we(a_instr_we),
    .pc_we(a_pc_we), .pc_sel(a_pc_sel), .rf_we(a_rf_we), .wb_sel(a_wb_sel),
    .state_o(a_state), .halted(a_halted), .illegal(a_illegal), .instret(a_instret)
  );

  rv32i_ctrl_fsm #(.HALT_ON_SYSTEM(0), .ILLEGAL_TRAP(0), .CNT_W(2)) u_nop (
    .clk(clk), .resetn(resetn), .instr(instr), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .addr_lsb(addr_lsb), .mem_rstrb(b_mem_rstrb),
    .mem_wmask(b_mem_wmask), .addr_sel(b_addr_sel), .instr_we(b_instr_we),
    .pc_we(b_pc_we), .pc_sel(b_pc_sel), .rf_we(b_rf_we), .wb_sel(b_wb_sel),
    .state_o(b_state), .halted(b_halted), .illegal(b_illegal), .instret(b_instret)
  );

  typedef struct packed {
    logic [1:0]  pc_sel;
    logic [1:0]  wb_sel;
    logic        rf_we;
    logic [31:0] instret;
  } retire_t;

  retire_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int m_instret  = 0;
  int m_instret2 = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_retire(input logic [1:0] ps, input logic [1:0] wb, input logic rw);
    retire_t e;
    e.pc_sel  = ps;
    e.wb_sel  = wb;
    e.rf_we   = rw;
    e.instret = m_instret;
    sb_q.push_back(e);
    m_instret++;
    m_instret2++;
  endtask

  always @(negedge clk) begin : mon
    retire_t e;
    if (resetn === 1'b1 && a_pc_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk_eq("sb_unexpected_retire", a_pc_we, 1'b0);
      end else begin
        e = sb_q.pop_front();
        chk_eq("sb_pc_sel", a_pc_sel, e.pc_sel);
        chk_eq("sb_wb_sel", a_wb_sel, e.wb_sel);
        chk_eq("sb_rf_we", a_rf_we, e.rf_we);
        chk_eq("sb_instret", a_instret, e.instret);
      end
    end
  end

  task automatic fetch_chk(input string tag);
    #1;
    chk_eq({tag, "_s0"}, a_state, 3'd0);
    chk_eq({tag, "_rstrb"}, a_mem_rstrb, 1'b1);
    tick();
    #1;
    chk_eq({tag, "_s1"}, a_state, 3'd1);
    chk_eq({tag, "_instr_we"}, a_instr_we, 1'b1);
    tick();
    #1;
    chk_eq({tag, "_s2"}, a_state, 3'd2);
    tick();
  endtask

  task automatic end_chk(input string tag);
    #1;
    chk_eq({tag, "_done_s0"}, a_state, 3'd0);
    chk_eq({tag, "_instret"}, a_instret, m_instret);
    chk_eq({tag, "_instret2"}, b_instret, m_instret2 % 4);
  endtask

  task automatic run_simple(input string tag, input logic [31:0] ins, input logic br,
                            input logic [1:0] ps, input logic [1:0] wb, input logic rw);
    instr = ins; branch_taken = br; mem_ready = 1'b1; addr_lsb = 2'd0;
    push_retire(ps, wb, rw);
    fetch_chk(tag);
    #1;
    chk_eq({tag, "_s3"}, a_state, 3'd3);
    chk_eq({tag, "_pc_we"}, a_pc_we, 1'b1);
    chk_eq({tag, "_rf_we"}, a_rf_we, rw);
    tick();
    end_chk(tag);
  endtask

  task automatic run_store(input string tag, input logic [31:0] ins, input logic [1:0] lsb,
                           input logic [3:0] mask, input int waits);
    instr = ins; branch_taken = 1'b0; mem_ready = 1'b1; addr_lsb = lsb;
    push_retire(2'd0, 2'd0, 1'b0);
    fetch_chk(tag);
    #1;
    chk_eq({tag, "_s3_no_pc_we"}, a_pc_we, 1'b0);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < waits; i++) begin
      #1;
      chk_eq({tag, "_wait_s6"}, a_state, 3'd6);
      chk_eq({tag, "_wait_mask"}, a_mem_wmask, mask);
      chk_eq({tag, "_wait_pc_we"}, a_pc_we, 1'b0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk_eq({tag, "_s6"}, a_state, 3'd6);
    chk_eq({tag, "_mask"}, a_mem_wmask, mask);
    chk_eq({tag, "_addr_sel"}, a_addr_sel, 1'b1);
    tick();
    end_chk(tag);
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    tick();
    #1;
    chk_eq({tag, "_rst_state"}, a_state, 3'd0);
    chk_eq({tag, "_rst_instret"}, a_instret, 32'd0);
    chk_eq({tag, "_rst_illegal"}, a_illegal, 1'b0);
    chk_eq({tag, "_rst_halted"}, a_halted, 1'b0);
    chk_eq({tag, "_rst_state2"}, b_state, 3'd0);
    chk_eq({tag, "_rst_instret2"}, b_instret, 2'd0);
    chk_eq({tag, "_sb_empty"}, sb_q.size(), 0);
    sb_q.delete();
    m_instret = 0;
    m_instret2 = 0;
    resetn = 1'b1;
  endtask

  task automatic run_trap(input string tag, input logic [31:0] ins, input logic [1:0] lsb,
                          input logic exp_illegal);
    instr = ins; branch_taken = 1'b0; mem_ready = 1'b1; addr_lsb = lsb;
    fetch_chk(tag);
    #1;
    chk_eq({tag, "_a_pc_we"}, a_pc_we, 1'b0);
    chk_eq({tag, "_b_pc_we"}, b_pc_we, 1'b1);
    chk_eq({tag, "_b_pc_sel"}, b_pc_sel, 2'd0);
    m_instret2++;
    tick();
    #1;
    chk_eq({tag, "_halt_state"}, a_state, 3'd7);
    chk_eq({tag, "_halted"}, a_halted, 1'b1);
    chk_eq({tag, "_illegal"}, a_illegal, exp_illegal);
    chk_eq({tag, "_b_state"}, b_state, 3'd0);
    chk_eq({tag, "_b_instret"}, b_instret, m_instret2 % 4);
    tick();
    tick();
    #1;
    chk_eq({tag, "_hold_state"}, a_state, 3'd7);
    chk_eq({tag, "_hold_rstrb"}, a_mem_rstrb, 1'b0);
    chk_eq({tag, "_hold_wmask"}, a_mem_wmask, 4'd0);
    chk_eq({tag, "_hold_illegal"}, a_illegal, exp_illegal);
    chk_eq({tag, "_hold_instret"}, a_instret, m_instret);
    do_reset(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; instr = 32'h00000013; branch_taken = 1'b0;
    mem_ready = 1'b0; addr_lsb = 2'd0;
    tick();
    tick();
    do_reset("init");

    run_simple("add", 32'h003100B3, 1'b0, 2'd0, 2'd0, 1'b1);

    instr = 32'h0000A103; mem_ready = 1'b1; addr_lsb = 2'd0; branch_taken = 1'b0;
    push_retire(2'd0, 2'd2, 1'b1);
    fetch_chk("lw");
    #1;
    chk_eq("lw_s3", a_state, 3'd3);
    chk_eq("lw_s3_pc_we", a_pc_we, 1'b0);
    tick();
    #1;
    chk_eq("lw_s4", a_state, 3'd4);
    chk_eq("lw_s4_rstrb", a_mem_rstrb, 1'b1);
    chk_eq("lw_s4_addr_sel", a_addr_sel, 1'b1);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_eq("lw_wait_s5", a_state, 3'd5);
      chk_eq("lw_wait_rf_we", a_rf_we, 1'b0);
      chk_eq("lw_wait_addr_sel", a_addr_sel, 1'b1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk_eq("lw_ready_s5", a_state, 3'd5);
    chk_eq("lw_ready_rf_we", a_rf_we, 1'b1);
    chk_eq("lw_ready_wb_sel", a_wb_sel, 2'd2);
    tick();
    end_chk("lw");

    run_store("sb", 32'h00208023, 2'd2, 4'b0100, 1);
    run_store("sh", 32'h00209023, 2'd2, 4'b1100, 0);
    run_store("sw", 32'h0020A023, 2'd0, 4'b1111, 2);

    run_simple("beq_t", 32'h00208063, 1'b1, 2'd1, 2'd0, 1'b0);
    run_simple("beq_n", 32'h00208063, 1'b0, 2'd0, 2'd0, 1'b0);
    run_simple("jal", 32'h000000EF, 1'b0, 2'd1, 2'd1, 1'b1);
    run_simple("jalr", 32'h000100E7, 1'b0, 2'd2, 2'd1, 1'b1);
    run_simple("lui", 32'h000012B7, 1'b0, 2'd0, 2'd3, 1'b1);
    run_simple("addi_x0", 32'h00500013, 1'b0, 2'd0, 2'd0, 1'b0);

    // abort a fetch that is still waiting on memory
    instr = 32'h003100B3; mem_ready = 1'b0;
    tick();
    tick();
    #1;
    chk_eq("midwait_s1", a_state, 3'd1);
    chk_eq("midwait_instr_we", a_instr_we, 1'b0);
    chk_eq("midwait_instret", a_instret, m_instret);
    do_reset("midwait");

    run_trap("sw_mis", 32'h0020A023, 2'd1, 1'b1);
    run_trap("bad_op", 32'h0000007F, 2'd0, 1'b1);
    run_trap("st_f3", 32'h0020B023, 2'd0, 1'b1);
    run_trap("ebreak", 32'h00100073, 2'd0, 1'b0);

    chk_eq("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
